// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: small circular buffer with
// first-word-fall-through head, flush and async reset.
module if_id_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_valid,
  input  logic [31:0]   push_I,
  input  logic [31:0]   push_PC,
  input  logic          push_BD,
  output logic          push_ready,
  input  logic          pop_ready,
  output logic          pop_valid,
  output logic [31:0]   I,
  output logic [31:0]   PC,
  output logic          BD,
  input  logic          flush,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] pc;
    logic        bd;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  assign push_ready = (cnt != CW'(DEPTH));
  assign pop_valid  = (cnt != '0);
  assign do_push    = push_valid && push_ready && !flush;
  assign do_pop     = pop_valid && pop_ready && !flush;
  assign count      = cnt;

  // Head is read straight from storage; empty shows a nop at RESET_PC
  always_comb begin
    head = mem[rd_ptr];
    I    = 32'h0;
    PC   = RESET_PC;
    BD   = 1'b0;
    if (pop_valid) begin
      I  = head.i;
      PC = head.pc;
      BD = head.bd;
    end
  end

  // Storage is only written by an accepted push; never cleared
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= '{i: push_I, pc: push_PC, bd: push_BD};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed steps plus random traffic
// checked against a queue-based reference model.
module tb_if_id_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          CW       = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          push_valid;
  logic [31:0]   push_I;
  logic [31:0]   push_PC;
  logic          push_BD;
  logic          push_ready;
  logic          pop_ready;
  logic          pop_valid;
  logic [31:0]   I;
  logic [31:0]   PC;
  logic          BD;
  logic          flush;
  logic [CW-1:0] count;

  typedef struct {
    logic [31:0] i;
    logic [31:0] pc;
    logic        bd;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  if_id_queue #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .push_valid(push_valid),
    .push_I(push_I),
    .push_PC(push_PC),
    .push_BD(push_BD),
    .push_ready(push_ready),
    .pop_ready(pop_ready),
    .pop_valid(pop_valid),
    .I(I),
    .PC(PC),
    .BD(BD),
    .flush(flush),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int          n;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        eb;
    n  = q.size();
    ei = 32'h0;
    ep = RESET_PC;
    eb = 1'b0;
    if (n != 0) begin
      ei = q[0].i;
      ep = q[0].pc;
      eb = q[0].bd;
    end
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".pop_valid"}, 32'(pop_valid), 32'(n != 0));
    chk({tag, ".push_ready"}, 32'(push_ready), 32'(n != DEPTH));
    chk({tag, ".I"}, I, ei);
    chk({tag, ".PC"}, PC, ep);
    chk({tag, ".BD"}, 32'(BD), 32'(eb));
  endtask

  // One clock cycle: drive, check current head state, then
  // advance the model by the queue's rules at the edge.
  task automatic cycle(input string       tag,
                       input logic        pv,
                       input logic [31:0] ii,
                       input logic [31:0] pc,
                       input logic        bd,
                       input logic        pr,
                       input logic        fl);
    ent_t e;
    bit   acc_push;
    bit   acc_pop;
    push_valid = pv;
    push_I     = ii;
    push_PC    = pc;
    push_BD    = bd;
    pop_ready  = pr;
    flush      = fl;
    check_outputs(tag);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      acc_pop  = (q.size() != 0) && pr;
      acc_push = pv && (q.size() != DEPTH);
      if (acc_pop) void'(q.pop_front());
      if (acc_push) begin
        e.i  = ii;
        e.pc = pc;
        e.bd = bd;
        q.push_back(e);
      end
    end
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    push_valid = 1'b0;
    push_I     = '0;
    push_PC    = '0;
    push_BD    = 1'b0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_hold");
    reset = 1'b1;
    check_outputs("rst_idle");

    for (int k = 0; k < 3; k++)
      cycle("fifo_push", 1'b1, 32'(8'h11 * (k + 1)),
            32'h3000 + 32'(4 * k), k[0], 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      cycle("fifo_pop", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    check_outputs("fifo_empty");

    for (int k = 0; k < 4; k++)
      cycle("full_fill", 1'b1, 32'hA0 + 32'(k),
            32'h4000 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    chk("full_ready", 32'(push_ready), 32'd0);
    cycle("full_pp", 1'b1, 32'hDEAD, 32'h5000, 1'b1, 1'b1, 1'b0);
    chk("full_cnt3", 32'(count), 32'd3);
    for (int k = 0; k < 3; k++)
      cycle("full_drain", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

    cycle("wrap_first", 1'b1, 32'h100, 32'h3000, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k < 10; k++)
      cycle("wrap_pp", 1'b1, 32'h100 + 32'(k),
            32'h3000 + 32'(4 * k), 1'b0, 1'b1, 1'b0);
    chk("wrap_cnt", 32'(count), 32'd1);
    cycle("wrap_last", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

    cycle("fl_fill", 1'b1, 32'h55, 32'h6000, 1'b1, 1'b0, 1'b0);
    cycle("fl_fill", 1'b1, 32'h66, 32'h6004, 1'b0, 1'b0, 1'b0);
    cycle("fl_do", 1'b1, 32'h77, 32'h6008, 1'b1, 1'b1, 1'b1);
    chk("fl_cnt", 32'(count), 32'd0);
    chk("fl_pc", PC, RESET_PC);
    check_outputs("fl_after");

    for (int k = 0; k < 3; k++)
      cycle("ar_fill", 1'b1, 32'h80 + 32'(k),
            32'h7000 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    push_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    chk("ar_cnt_now", 32'(count), 32'd0);
    check_outputs("ar_now");
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycle("ar_push", 1'b1, 32'h99, 32'h8888_0004, 1'b1, 1'b0, 1'b0);
    chk("ar_cnt1", 32'(count), 32'd1);
    chk("ar_pc", PC, 32'h8888_0004);
    cycle("ar_drain", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 400; k++)
      cycle("rnd", 1'($urandom), $urandom, $urandom,
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 15) == 0));
    check_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DEPTH, default 4: number of entries; power of two, 2..16.
REQ-003 Parameter RESET_PC, default 32'h00003000: PC presented while empty and after reset.
REQ-004 Parameter CW, default $clog2(DEPTH+1): width of count.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-007 push_valid  input  1  IF offers an entry this cycle.
REQ-008 push_I  input  32  fetched instruction.
REQ-009 push_PC  input  32  PC of the fetched instruction.
REQ-010 push_BD  input  1  instruction sits in a branch delay slot.
REQ-011 push_ready  output  1  queue accepts an entry this cycle.
REQ-012 pop_ready  input  1  ID consumes the head entry this cycle (stall when 0).
REQ-013 pop_valid  output  1  head entry is valid.
REQ-014 I, PC  output  32 each  head instruction and PC.
REQ-015 BD  output  1  head delay-slot flag.
REQ-016 flush  input  1  discard all entries (branch redirect, exception, eret).
REQ-017 count  output  CW  number of valid entries, 0..DEPTH.

Function
REQ-018 Storage: DEPTH-entry circular buffer of {I, PC, BD}; read pointer, write pointer and count SHALL be registers updated on rising clk only.
REQ-019 Push: entry written at write pointer when push_valid && push_ready && !flush; write pointer advances by 1 modulo DEPTH.
REQ-020 Pop: head retired when pop_valid && pop_ready && !flush; read pointer advances by 1 modulo DEPTH.
REQ-021 push_ready SHALL equal (count != DEPTH); combinational from count only, independent of pop_ready.
REQ-022 pop_valid SHALL equal (count != 0).
REQ-023 Outputs are first-word-fall-through: I, PC, BD SHALL show the head entry combinationally from storage at the read pointer while pop_valid=1.
REQ-024 While empty, I SHALL be 0 (nop), PC SHALL be RESET_PC, BD SHALL be 0.
REQ-025 Count update: +1 on push only, -1 on pop only, unchanged on push and pop in the same cycle.
REQ-026 Full: push_ready=0, push_valid ignored, even when a pop occurs in that cycle.
REQ-027 Empty: pop_ready ignored; a push in that cycle becomes visible at the head on the next cycle (no bypass, zero-latency path not provided).
REQ-028 Flush has priority: both pointers and count SHALL be 0 at the next edge; any push or pop in that cycle SHALL be discarded.
REQ-029 Latency: an accepted entry SHALL reach the head no earlier than 1 cycle after acceptance; FIFO order SHALL be preserved across pointer wrap-around.
REQ-030 Stored entry contents SHALL NOT change except by a write of that slot.

Reset
REQ-031 reset=0 SHALL asynchronously clear the read pointer, write pointer and count to 0, giving pop_valid=0, push_ready=1, count=0, I=0, PC=RESET_PC and BD=0.
REQ-032 Storage contents need not be cleared.
REQ-033 Reset asserted mid-operation SHALL drop all entries, including any push in progress.
REQ-034 After reset=1, the first rising edge SHALL accept a push normally.

Verification
REQ-035 Reset, no traffic -> count=0, pop_valid=0, push_ready=1, I=0, PC=32'h00003000, BD=0.
REQ-036 Push PC 0x3000, 0x3004, 0x3008 (I 0x11,0x22,0x33); pop_ready=0 for 3 cycles, then 1 -> head order 0x3000, 0x3004, 0x3008; count 3 -> 0.
REQ-037 DEPTH=4: 4 pushes, then push_valid=1 with pop_ready=1 -> 5th entry rejected that cycle (push_ready=0); count 4 -> 3.
REQ-038 Continuous push+pop of 10 entries, PC 0x3000..0x3024 -> count constant, wrap-around order intact, no loss.
REQ-039 Count=2, flush=1 with push_valid=1 and pop_ready=1 -> next cycle count=0, pop_valid=0, PC=32'h00003000.
REQ-040 Count=3, reset pulsed low between edges -> count=0 immediately with no clock edge; a push after release gives count=1 and PC equal to the pushed value.
